// File: rtl/c1_wait_gen.sv
// DTACK/wait-state generator for the C1 68K bus: priority zone decode,
// per-zone wait counts, optional external acknowledge and bus-error timeout.
module c1_wait_gen #(
   parameter int ZONES    = 4,
   parameter int CNT_W    = 2,
   parameter int DEF_WAIT = 0,
   parameter int TO_W     = 6,
   parameter int TIMEOUT  = 48
) (
   input  logic                   CLK_68KCLK,
   input  logic                   RESET,
   input  logic                   nAS,
   input  logic [ZONES-1:0]       nZONE,
   input  logic [ZONES*CNT_W-1:0] WAIT_CFG,
   input  logic [ZONES-1:0]       EXT_MODE,
   input  logic                   nEXT_DTACK,
   input  logic                   TIMEOUT_EN,
   output logic                   nDTACK,
   output logic                   nBERR,
   output logic                   BUSY
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      EXTWAIT,
      ACK,
      BERR
   } state_t;

   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             ext_sel;
   logic             ext_sel_nx;
   logic [TO_W-1:0]  tcnt;
   logic [TO_W-1:0]  tcnt_nx;
   logic [TO_W-1:0]  tcnt_inc;
   logic             timeout_hit;
   logic [CNT_W-1:0] hit_wait;
   logic             hit_ext;
   logic             busy_nx;

   // Lowest-index active zone wins; scanning downward lets it overwrite the rest.
   always_comb begin
      hit_wait = CNT_W'(DEF_WAIT);
      hit_ext  = 1'b0;
      for (int i = ZONES - 1; i >= 0; i--) begin
         if (!nZONE[i]) begin
            hit_wait = WAIT_CFG[i*CNT_W +: CNT_W];
            hit_ext  = EXT_MODE[i];
         end
      end
   end

   // The timeout counter parks one short of TIMEOUT so a disabled timeout never wraps.
   assign tcnt_inc    = (tcnt == TO_LAST) ? tcnt : tcnt + 1'b1;
   assign timeout_hit = TIMEOUT_EN && (tcnt == TO_LAST);

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      ext_sel_nx = ext_sel;
      tcnt_nx    = tcnt;
      case (state)
         IDLE: begin
            if (!nAS) begin
               cnt_nx     = hit_wait;
               ext_sel_nx = hit_ext;
               tcnt_nx    = '0;
               if (hit_wait != CNT_ZERO) begin
                  state_nx = COUNT;
               end else if (hit_ext) begin
                  state_nx = EXTWAIT;
               end else begin
                  state_nx = ACK;
               end
            end
         end
         COUNT: begin
            if (nAS) begin
               state_nx = IDLE;
            end else begin
               cnt_nx  = cnt - 1'b1;
               tcnt_nx = tcnt_inc;
               if ((cnt == CNT_ONE) && !ext_sel) begin
                  state_nx = ACK;
               end else if (timeout_hit) begin
                  state_nx = BERR;
               end else if (cnt == CNT_ONE) begin
                  state_nx = EXTWAIT;
               end
            end
         end
         EXTWAIT: begin
            if (nAS) begin
               state_nx = IDLE;
            end else begin
               tcnt_nx = tcnt_inc;
               if (!nEXT_DTACK) begin
                  state_nx = ACK;
               end else if (timeout_hit) begin
                  state_nx = BERR;
               end
            end
         end
         ACK, BERR: begin
            if (nAS) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign busy_nx = (state_nx == COUNT) || (state_nx == EXTWAIT);

   always_ff @(negedge CLK_68KCLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         cnt     <= '0;
         ext_sel <= 1'b0;
         tcnt    <= '0;
         BUSY    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         ext_sel <= ext_sel_nx;
         tcnt    <= tcnt_nx;
         BUSY    <= busy_nx;
      end
   end

   // Gated with nAS so both strobes release the instant the CPU ends the cycle.
   assign nDTACK = nAS || (state != ACK);
   assign nBERR  = nAS || (state != BERR);

endmodule

// File: tb/tb_c1_wait_gen.sv
// Bench for c1_wait_gen: directed corner cases followed by random cycles,
// all checked against an offset-based model of when the cycle terminates.
module tb_c1_wait_gen;

   localparam int ZONES    = 4;
   localparam int CNT_W    = 2;
   localparam int DEF_WAIT = 2;
   localparam int TO_W     = 6;
   localparam int TIMEOUT  = 48;
   localparam int NEVER    = 100000;

   logic                   CLK_68KCLK;
   logic                   RESET;
   logic                   nAS;
   logic [ZONES-1:0]       nZONE;
   logic [ZONES*CNT_W-1:0] WAIT_CFG;
   logic [ZONES-1:0]       EXT_MODE;
   logic                   nEXT_DTACK;
   logic                   TIMEOUT_EN;
   logic                   nDTACK;
   logic                   nBERR;
   logic                   BUSY;

   int nAssert = 0;
   int nFail   = 0;

   c1_wait_gen #(
      .ZONES(ZONES), .CNT_W(CNT_W), .DEF_WAIT(DEF_WAIT), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK_68KCLK(CLK_68KCLK),
      .RESET(RESET),
      .nAS(nAS),
      .nZONE(nZONE),
      .WAIT_CFG(WAIT_CFG),
      .EXT_MODE(EXT_MODE),
      .nEXT_DTACK(nEXT_DTACK),
      .TIMEOUT_EN(TIMEOUT_EN),
      .nDTACK(nDTACK),
      .nBERR(nBERR),
      .BUSY(BUSY)
   );

   // Falling edges land at 10, 30, 50 ... ns.
   initial begin
      CLK_68KCLK = 1'b1;
      forever #10 CLK_68KCLK = ~CLK_68KCLK;
   end

   // Observe just after a falling edge; new stimulus is driven from here too.
   task automatic edgeStep();
      @(negedge CLK_68KCLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      nAssert++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic expDtack, input logic expBerr, input logic expBusy);
      checkOutput({tag, "_ndtack"}, nDTACK, expDtack);
      checkOutput({tag, "_nberr"}, nBERR, expBerr);
      checkOutput({tag, "_busy"}, BUSY, expBusy);
   endtask

   // One bus cycle. Latch happens at offset 0; the model derives, from the zone
   // rules alone, the offset at which the cycle ends in ACK or BERR.
   // extLowAt: first offset at which nEXT_DTACK is low. abortAt < 0: normal end.
   task automatic applyStimulus(input logic [3:0] zn, input logic [7:0] cfg, input logic [3:0] ext,
                                input int extLowAt, input logic ten, input int abortAt, input string name);
      int  zone;
      int  waitCnt;
      bit  extSel;
      int  ackOff;
      int  doneOff;
      bit  isAck;
      bit  isBerr;
      int  endOff;
      logic [7:0] cfgCopy;
      zone = -1;
      for (int i = 0; i < ZONES; i++) begin
         if (!zn[i] && zone < 0) zone = i;
      end
      cfgCopy = cfg;
      waitCnt = (zone < 0) ? DEF_WAIT : int'(cfgCopy[zone*CNT_W +: CNT_W]);
      extSel  = (zone < 0) ? 1'b0 : ext[zone];
      ackOff  = extSel ? ((waitCnt + 1 > extLowAt) ? waitCnt + 1 : extLowAt) : waitCnt;
      isAck   = 1'b0;
      isBerr  = 1'b0;
      if (!ten || ackOff <= TIMEOUT) begin
         isAck   = 1'b1;
         doneOff = ackOff;
      end else begin
         isBerr  = 1'b1;
         doneOff = TIMEOUT;
      end
      endOff = (abortAt < 0) ? doneOff + 2 : abortAt;

      nZONE      = zn;
      WAIT_CFG   = cfg;
      EXT_MODE   = ext;
      TIMEOUT_EN = ten;
      nEXT_DTACK = (extLowAt <= 0) ? 1'b0 : 1'b1;
      nAS        = 1'b0;
      for (int j = 0; j <= endOff + 1; j++) begin
         edgeStep();
         if (j >= endOff) begin
            checkAll($sformatf("%s_j%0d", name, j), 1'b1, 1'b1, 1'b0);
         end else begin
            checkAll($sformatf("%s_j%0d", name, j),
                     !(isAck && j >= doneOff), !(isBerr && j >= doneOff), j < doneOff);
         end
         if (j == 0) begin
            nZONE    = 4'($urandom);
            WAIT_CFG = 8'($urandom);
            EXT_MODE = 4'($urandom);
         end
         nEXT_DTACK = (j + 1 >= extLowAt) ? 1'b0 : 1'b1;
         if (j + 1 == endOff) begin
            nAS = 1'b1;
            #1;
            checkOutput({name, "_nas_rise_ndtack"}, nDTACK, 1'b1);
            checkOutput({name, "_nas_rise_nberr"}, nBERR, 1'b1);
         end
      end
      nEXT_DTACK = 1'b1;
   endtask

   // Asynchronous reset mid-COUNT (zone 0, W=3) or mid-ACK (zone 3, W=0).
   task automatic resetMid(input bit midAck);
      nZONE      = midAck ? 4'b0111 : 4'b1110;
      WAIT_CFG   = 8'h1B;
      EXT_MODE   = 4'h0;
      TIMEOUT_EN = 1'b1;
      nEXT_DTACK = 1'b1;
      nAS        = 1'b0;
      edgeStep();
      if (midAck) begin
         checkOutput("rst_pre_ack_ndtack", nDTACK, 1'b0);
      end else begin
         edgeStep();
         checkOutput("rst_pre_count_busy", BUSY, 1'b1);
      end
      RESET = 1'b1;
      #1;
      checkAll(midAck ? "rst_ack_now" : "rst_count_now", 1'b1, 1'b1, 1'b0);
      edgeStep();
      checkAll(midAck ? "rst_ack_held" : "rst_count_held", 1'b1, 1'b1, 1'b0);
      RESET = 1'b0;
      nAS   = 1'b1;
      edgeStep();
      edgeStep();
      checkAll(midAck ? "rst_ack_idle" : "rst_count_idle", 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      logic [3:0] rZone;
      logic [7:0] rCfg;
      logic [3:0] rExt;
      int         rLow;
      logic       rTen;
      int         rAbort;

      RESET      = 1'b1;
      nAS        = 1'b1;
      nZONE      = '1;
      WAIT_CFG   = '0;
      EXT_MODE   = '0;
      nEXT_DTACK = 1'b1;
      TIMEOUT_EN = 1'b0;
      edgeStep();
      edgeStep();
      checkAll("reset", 1'b1, 1'b1, 1'b0);
      RESET = 1'b0;
      edgeStep();
      checkAll("post_reset_idle", 1'b1, 1'b1, 1'b0);

      applyStimulus(4'b1110, 8'h1B, 4'h0, 0, 1'b1, -1, "zone0_w3");
      applyStimulus(4'b0111, 8'h1B, 4'h0, 0, 1'b1, -1, "zone3_w0");
      applyStimulus(4'b1100, 8'h1B, 4'h0, 0, 1'b1, -1, "prio_zone0");
      applyStimulus(4'b1111, 8'h1B, 4'h0, 0, 1'b1, -1, "def_wait");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, 4, 1'b1, -1, "ext_zone2");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, 0, 1'b1, -1, "ext_early");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, NEVER, 1'b1, -1, "timeout");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, TIMEOUT, 1'b1, -1, "timeout_tie");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, TIMEOUT + 1, 1'b1, -1, "timeout_late");
      applyStimulus(4'b1011, 8'h1B, 4'b0100, NEVER, 1'b0, 200, "no_timeout");
      applyStimulus(4'b1110, 8'h1B, 4'h0, 0, 1'b1, 1, "abort");
      applyStimulus(4'b1110, 8'h1B, 4'h0, 0, 1'b1, -1, "after_abort");

      resetMid(1'b0);
      applyStimulus(4'b1110, 8'h1B, 4'h0, 0, 1'b1, -1, "after_rst_count");
      resetMid(1'b1);
      applyStimulus(4'b1101, 8'h1B, 4'h0, 0, 1'b1, -1, "after_rst_ack");

      for (int t = 0; t < 40; t++) begin
         rZone  = 4'($urandom);
         rCfg   = 8'($urandom);
         rExt   = 4'($urandom);
         rLow   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(44, 52)) : int'($urandom_range(0, 6));
         rTen   = 1'($urandom_range(0, 1));
         rAbort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1;
         applyStimulus(rZone, rCfg, rExt, rLow, rTen, rAbort, $sformatf("rand%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/c1_wait_gen.md
# c1_wait_gen

Parametrised DTACK/wait-state generator for the 68K bus in the C1 system block. It decodes a configurable number of active-low zone selects and inserts a per-zone programmable number of wait cycles. Selected zones may also stretch the cycle until an external acknowledge arrives, with an optional bus-error timeout. Sits between the address decoder and the 68K nDTACK/nBERR inputs.

## Interface
Parameters:
- ZONES, 4, number of decoded zones (1..8); index 0 has highest priority
- CNT_W, 2, width of each per-zone wait count
- DEF_WAIT, 0, wait cycles for a bus cycle that hits no zone (must fit CNT_W)
- TO_W, 6, width of timeout counter
- TIMEOUT, 48, cycles from latch to bus error (1..2^TO_W-1)

Ports:
- CLK_68KCLK  in  1  68K clock; all state changes on its falling edge
- RESET  in  1  asynchronous, active-high reset
- nAS  in  1  68K address strobe
- nZONE  in  ZONES  active-low zone selects, one-hot or multiple (priority decode)
- WAIT_CFG  in  ZONES*CNT_W  wait count for zone i in bits [i*CNT_W +: CNT_W]
- EXT_MODE  in  ZONES  1 = zone i also waits for nEXT_DTACK after its count
- nEXT_DTACK  in  1  external acknowledge, active-low (e.g. cartridge PDTACK path)
- TIMEOUT_EN  in  1  enables bus-error generation
- nDTACK  out  1  data acknowledge to CPU
- nBERR  out  1  bus error to CPU
- BUSY  out  1  high while in COUNT or EXTWAIT

## Operation
- States: IDLE, COUNT, EXTWAIT, ACK, BERR. RESET forces IDLE, clears counters, regardless of clock.
- IDLE: on a falling edge with nAS low, latch winning zone z (lowest index with nZONE[z]=0), W = WAIT_CFG[z], E = EXT_MODE[z]; no zone -> W = DEF_WAIT, E = 0. Timeout counter cleared to 0.
  - W>0 -> COUNT with counter = W; W=0 and E=1 -> EXTWAIT; W=0 and E=0 -> ACK.
- COUNT: decrement each edge; when counter is 1 at the edge, go to EXTWAIT if E else ACK.
- EXTWAIT: at edge with nEXT_DTACK sampled low -> ACK.
- Timeout counter increments every edge in COUNT/EXTWAIT; when it would reach TIMEOUT and TIMEOUT_EN=1 -> BERR. If completion to ACK and timeout coincide, ACK wins. TIMEOUT_EN=0 -> wait indefinitely.
- ACK / BERR: hold until an edge samples nAS high -> IDLE.
- nAS sampled high in COUNT or EXTWAIT (aborted cycle) -> IDLE, no ACK or BERR ever issued for that cycle.
- Config inputs sampled only at latch; changes mid-cycle ignored.
- nDTACK = nAS OR (state != ACK); nBERR = nAS OR (state != BERR): both deassert combinationally the moment nAS rises. BUSY registered from state.

## Timing
- Reset values: nDTACK=1, nBERR=1, BUSY=0.
- Latch edge k (first falling edge with nAS low). nDTACK low after edge k+W when E=0 (W=0: after edge k itself).
- E=1: nDTACK low after first edge ≥ k+W+1 at which nEXT_DTACK is low (nEXT_DTACK already low at k+W: ack after k+W+1).
- nBERR low after edge k+TIMEOUT if not yet acked.
- Back-to-back cycles: one edge in IDLE with nAS high required between cycles; the new latch happens on the next edge with nAS low.
- Zone decode and WAIT_CFG must be stable at edge k.

## Test plan
- ZONES=4, WAIT_CFG={0,1,2,3} for zones 3..0; access zone 0 (W=3) -> nDTACK low after edge k+3; zone 3 (W=0) -> low after edge k; nAS rise -> nDTACK high same instant.
- nZONE=4'b1100 (zones 0,1 both low) -> zone 0 wins, W from zone 0; no zone low with DEF_WAIT=2 -> ack after k+2.
- Zone 2 EXT_MODE=1, W=1, nEXT_DTACK low at edge k+4 -> nDTACK low after k+4; BUSY high edges k..k+3.
- TIMEOUT_EN=1, TIMEOUT=48, EXT zone, nEXT_DTACK never asserted -> nBERR low after edge k+48, nDTACK stays high; with TIMEOUT_EN=0 -> no BERR after 200 cycles.
- nAS raised at k+1 during W=3 count -> IDLE, no nDTACK pulse; next cycle acks normally.
- RESET asserted mid-COUNT and mid-ACK -> outputs 1/1/0 immediately, next cycle starts clean from IDLE.
